// File: rtl/casez_seq_ctrl.sv
// Burst sequencer producing the registered 3-bit phase code for the casez decode stage.
// Phase groups: 000/001 idle-side, 01? active, 1?? terminal.
module casez_seq_ctrl #(
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             valid,
    input  logic             abort,
    input  logic             clear,
    output logic [2:0]       state,
    output logic             busy,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             err
);

    localparam int unsigned IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        ARM  = 3'b001,
        RUN  = 3'b010,
        LAST = 3'b011,
        DONE = 3'b100,
        ERR  = 3'b110
    } state_e;

    // Plain vector so the unused codes 101/111 stay representable and recoverable.
    logic [2:0]        state_q;
    logic [CNT_W-1:0]  remaining;
    logic [CNT_W-1:0]  beat_q;
    logic [IDLE_W-1:0] idle_cnt;
    logic              timeout_hit;

    assign timeout_hit = (idle_cnt == IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            remaining <= '0;
            beat_q    <= '0;
            idle_cnt  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        beat_q   <= '0;
                        idle_cnt <= '0;
                        if (len != '0) begin
                            remaining <= len;
                            state_q   <= ARM;
                        end else begin
                            remaining <= '0;
                            state_q   <= DONE;
                        end
                    end
                end
                ARM: begin
                    state_q <= (remaining == CNT_W'(1)) ? LAST : RUN;
                end
                RUN: begin
                    if (abort) begin
                        state_q <= ERR;
                    end else if (valid) begin
                        beat_q    <= beat_q + CNT_W'(1);
                        remaining <= remaining - CNT_W'(1);
                        idle_cnt  <= '0;
                        if (remaining == CNT_W'(2))
                            state_q <= LAST;
                    end else if (timeout_hit) begin
                        state_q <= ERR;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
                LAST: begin
                    if (abort) begin
                        state_q <= ERR;
                    end else if (valid) begin
                        beat_q    <= beat_q + CNT_W'(1);
                        remaining <= remaining - CNT_W'(1);
                        idle_cnt  <= '0;
                        state_q   <= DONE;
                    end else if (timeout_hit) begin
                        state_q <= ERR;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                ERR: begin
                    if (clear)
                        state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign state    = state_q;
    assign busy     = (state_q == ARM) || (state_q == RUN) || (state_q == LAST);
    assign err      = (state_q == ERR);
    assign beat_cnt = beat_q;

endmodule

// File: tb/tb_casez_seq_ctrl.sv
// Directed bench for casez_seq_ctrl: burst flows, timeout, abort, illegal codes, async reset.
module tb_casez_seq_ctrl;

    logic       clk;
    logic       rstn;
    logic       start;
    logic [3:0] len;
    logic       valid;
    logic       abort;
    logic       clear;
    logic [2:0] state;
    logic       busy;
    logic [3:0] beat_cnt;
    logic       err;

    int n_cmp;
    int n_bad;

    casez_seq_ctrl #(.CNT_W(4), .TIMEOUT(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .len      (len),
        .valid    (valid),
        .abort    (abort),
        .clear    (clear),
        .state    (state),
        .busy     (busy),
        .beat_cnt (beat_cnt),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; len = '0; valid = 1'b0; abort = 1'b0; clear = 1'b0;
        #2;
        n_cmp++;
        if (state !== 3'b000 || busy !== 1'b0 || err !== 1'b0 || beat_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL reset: state=%b busy=%b err=%b beat=%0d, required 000/0/0/0", state, busy, err, beat_cnt);
        end
        @(negedge clk);
        rstn = 1'b1;
        tick();
        n_cmp++;
        if (state !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_release: state=%b, required 000", state);
        end
    endtask

    task automatic test_burst3();
        logic [2:0] exp_seq [6] = '{3'b001, 3'b010, 3'b010, 3'b011, 3'b100, 3'b000};
        int busy_cycles = 0;
        start = 1'b1; len = 4'd3; valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) start = 1'b0;
            busy_cycles += int'(busy);
            n_cmp++;
            if (state !== exp_seq[i]) begin
                n_bad++;
                $display("FAIL burst3_seq[%0d]: state=%b, required %b", i, state, exp_seq[i]);
            end
        end
        valid = 1'b0;
        n_cmp++;
        if (beat_cnt !== 4'd3) begin
            n_bad++;
            $display("FAIL burst3_beats: beat_cnt=%0d, required 3", beat_cnt);
        end
        n_cmp++;
        if (busy_cycles != 4) begin
            n_bad++;
            $display("FAIL burst3_busy: busy cycles=%0d, required 4", busy_cycles);
        end
    endtask

    task automatic test_len1();
        start = 1'b1; len = 4'd1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (state !== 3'b001 || beat_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL len1_arm: state=%b beat=%0d, required 001/0", state, beat_cnt);
        end
        tick();
        n_cmp++;
        if (state !== 3'b011) begin
            n_bad++;
            $display("FAIL len1_last: state=%b, required 011", state);
        end
        valid = 1'b1;
        tick();
        valid = 1'b0;
        n_cmp++;
        if (state !== 3'b100 || beat_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL len1_done: state=%b beat=%0d, required 100/1", state, beat_cnt);
        end
        tick();
        n_cmp++;
        if (state !== 3'b000) begin
            n_bad++;
            $display("FAIL len1_idle: state=%b, required 000", state);
        end
    endtask

    task automatic test_len0();
        start = 1'b1; len = 4'd0;
        tick();
        n_cmp++;
        if (state !== 3'b100 || busy !== 1'b0 || beat_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL len0_done: state=%b busy=%b beat=%0d, required 100/0/0", state, busy, beat_cnt);
        end
        // start still high in DONE must be ignored
        tick();
        start = 1'b0;
        n_cmp++;
        if (state !== 3'b000 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL len0_idle: state=%b busy=%b, required 000/0", state, busy);
        end
    endtask

    task automatic test_timeout();
        start = 1'b1; len = 4'd4;
        tick();
        start = 1'b0;
        tick();
        valid = 1'b1;
        tick();
        valid = 1'b0;
        n_cmp++;
        if (state !== 3'b010 || beat_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL timeout_beat: state=%b beat=%0d, required 010/1", state, beat_cnt);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_cmp++;
            if (state !== ((k < 8) ? 3'b010 : 3'b110)) begin
                n_bad++;
                $display("FAIL timeout_idle[%0d]: state=%b, required %b", k, state, (k < 8) ? 3'b010 : 3'b110);
            end
        end
        n_cmp++;
        if (err !== 1'b1 || beat_cnt !== 4'd1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_err: err=%b beat=%0d busy=%b, required 1/1/0", err, beat_cnt, busy);
        end
        valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (state !== 3'b110 || beat_cnt !== 4'd1) begin
                n_bad++;
                $display("FAIL err_hold[%0d]: state=%b beat=%0d, required 110/1", k, state, beat_cnt);
            end
        end
        valid = 1'b0;
        clear = 1'b1; start = 1'b1; len = 4'd2;
        tick();
        clear = 1'b0; start = 1'b0;
        n_cmp++;
        if (state !== 3'b000 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear: state=%b err=%b, required 000/0", state, err);
        end
        tick();
        n_cmp++;
        if (state !== 3'b000) begin
            n_bad++;
            $display("FAIL err_clear_hold: state=%b, required 000", state);
        end
    endtask

    task automatic test_abort();
        start = 1'b1; len = 4'd5;
        tick();
        start = 1'b0;
        tick();
        valid = 1'b1;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0; valid = 1'b0;
        n_cmp++;
        if (state !== 3'b110 || beat_cnt !== 4'd1 || err !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_prio: state=%b beat=%0d err=%b, required 110/1/1", state, beat_cnt, err);
        end
        clear = 1'b1;
        tick();
        n_cmp++;
        if (state !== 3'b000) begin
            n_bad++;
            $display("FAIL abort_clear: state=%b, required 000", state);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0; clear = 1'b0;
        n_cmp++;
        if (state !== 3'b000 || beat_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL idle_noop: state=%b beat=%0d, required 000/1", state, beat_cnt);
        end
    endtask

    task automatic test_illegal();
        logic [2:0] bad_codes [2] = '{3'b101, 3'b111};
        for (int i = 0; i < 2; i++) begin
            force dut.state_q = bad_codes[i];
            #1;
            release dut.state_q;
            #1;
            n_cmp++;
            if (state !== bad_codes[i]) begin
                n_bad++;
                $display("FAIL illegal_load[%0d]: state=%b, required %b", i, state, bad_codes[i]);
            end
            tick();
            n_cmp++;
            if (state !== 3'b000 || beat_cnt !== 4'd1) begin
                n_bad++;
                $display("FAIL illegal_recover[%0d]: state=%b beat=%0d, required 000/1", i, state, beat_cnt);
            end
        end
    endtask

    task automatic test_async_reset();
        start = 1'b1; len = 4'd5;
        tick();
        start = 1'b0;
        tick();
        valid = 1'b1;
        tick();
        valid = 1'b0;
        n_cmp++;
        if (state !== 3'b010 || beat_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL async_pre: state=%b beat=%0d, required 010/1", state, beat_cnt);
        end
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (state !== 3'b000 || beat_cnt !== 4'd0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: state=%b beat=%0d busy=%b, required 000/0/0", state, beat_cnt, busy);
        end
        @(negedge clk);
        rstn = 1'b1;
        tick();
        n_cmp++;
        if (state !== 3'b000) begin
            n_bad++;
            $display("FAIL async_release: state=%b, required 000", state);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_burst3();
        test_len1();
        test_len0();
        test_timeout();
        test_abort();
        test_illegal();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
